// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 16-bit core.
// Drives the single-port data memory, range-checks every access,
// captures load data / ALU results into the MEM/WB register, and keeps
// a sticky fault record plus retired load/store counters.
module mem_stage #(
  parameter int DEPTH = 128,
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int RW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  input  logic [1:0]    ex_op,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_wdata,
  input  logic [DW-1:0] ex_alu,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_regwrite,
  input  logic          hold,
  input  logic          flush,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  input  logic [DW-1:0] dm_dout,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          wb_regwrite,
  output logic          fault,
  output logic [AW-1:0] fault_addr,
  output logic [15:0]   load_count,
  output logic [15:0]   store_count
);

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  // Extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          regwrite;
  } wb_t;

  logic          w_live;
  logic          w_in_range;
  logic          w_is_alu;
  logic          w_is_ld;
  logic          w_is_st;
  logic          w_st_issue;
  logic          w_fault_hit;
  wb_t           w_wb_next;

  wb_t           r_wb;
  logic          r_st_done;
  logic          r_fault;
  logic [AW-1:0] r_fault_addr;
  logic [15:0]   r_load_count;
  logic [15:0]   r_store_count;

  assign w_live      = ex_valid & ~flush;
  assign w_in_range  = ({1'b0, ex_addr} < LP_DEPTH);
  assign w_is_alu    = (ex_op == OP_ALU);
  assign w_is_ld     = (ex_op == OP_LOAD);
  assign w_is_st     = (ex_op == OP_STORE);

  // A held store writes memory once; st_done blocks the repeats.
  // Reset also gates the write so nothing lands in memory while it is high.
  assign w_st_issue  = w_live & w_is_st & w_in_range & ~r_st_done & ~reset;
  assign w_fault_hit = w_live & (w_is_ld | w_is_st) & ~w_in_range;

  assign dm_addr = ex_addr;
  assign dm_din  = ex_wdata;
  assign dm_we   = w_st_issue;

  // Next MEM/WB contents; out-of-range loads and no-op/store slots return 0.
  always_comb begin
    w_wb_next          = '0;
    w_wb_next.valid    = w_live;
    w_wb_next.rd       = ex_rd;
    w_wb_next.regwrite = w_live & ex_regwrite & (w_is_alu | w_is_ld);
    if (w_is_ld && w_in_range)
      w_wb_next.data = dm_dout;
    else if (w_is_alu)
      w_wb_next.data = ex_alu;
  end

  // MEM/WB register: frozen while downstream holds.
  always_ff @(posedge clk) begin
    if (reset)
      r_wb <= '0;
    else if (!hold)
      r_wb <= w_wb_next;
  end

  // Remember that the currently held store has already written memory.
  always_ff @(posedge clk) begin
    if (reset)
      r_st_done <= 1'b0;
    else if (!hold)
      r_st_done <= 1'b0;
    else if (w_st_issue)
      r_st_done <= 1'b1;
  end

  // Sticky fault; only the first offending address is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_fault_hit && !r_fault) begin
      r_fault      <= 1'b1;
      r_fault_addr <= ex_addr;
    end
  end

  // Retired in-range loads count when the load leaves the stage.
  always_ff @(posedge clk) begin
    if (reset)
      r_load_count <= '0;
    else if (!hold && w_live && w_is_ld && w_in_range)
      r_load_count <= r_load_count + 16'd1;
  end

  // Stores count on the single edge where they actually write.
  always_ff @(posedge clk) begin
    if (reset)
      r_store_count <= '0;
    else if (w_st_issue)
      r_store_count <= r_store_count + 16'd1;
  end

  assign wb_valid    = r_wb.valid;
  assign wb_rd       = r_wb.rd;
  assign wb_data     = r_wb.data;
  assign wb_regwrite = r_wb.regwrite;
  assign fault       = r_fault;
  assign fault_addr  = r_fault_addr;
  assign load_count  = r_load_count;
  assign store_count = r_store_count;

endmodule
